// File: rtl/muldiv_alu_seq.sv
// rtl/muldiv_alu_seq.sv - multi-cycle MULTU/DIVU HI/LO unit that borrows the shared EX-stage ALU
//
// Optional feature macro: MULDIV_SIGNED_EN (signed MULT/DIV through abs-value operands
// plus a one-cycle FIX state). Without it is_signed is ignored and all operations are unsigned.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, is_div        request from EX; 1 = divide, 0 = multiply (sampled at start)
//   is_signed            signed request (only honoured with MULDIV_SIGNED_EN)
//   opa, opb             rs / rt operands
//   alu_y                shared ALU result (combinational return path)
//   alu_grant            ALU inputs come from this block
//   alu_op, alu_a, alu_b ALU control and operands while granted
//   stall, busy, done    pipeline freeze, operation in progress, one-cycle result pulse
//   hi, lo               HI/LO registers for MFHI/MFLO
module muldiv_alu_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_div,
    input  logic            is_signed,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    input  logic [XLEN-1:0] alu_y,
    output logic            alu_grant,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
`ifdef MULDIV_SIGNED_EN
    localparam logic [2:0] S_FIX  = 3'd3;
`endif
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_ZERO = 4'b1000;

    logic [2:0]      state;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0] mreg;        // multiplicand or divisor, depending on the operation
    logic            accept;
    logic [XLEN-1:0] sh;
    logic            carry;
    logic            ge;
    logic            last;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [2:0]      exit_state;

    assign accept = start && (state == S_IDLE || state == S_DONE);
    assign last   = (count == '1);

    // Multiply: the ALU add may overflow 32 bits; the lost carry is recovered
    // by noticing the sum wrapped below the addend hi.
    assign carry  = (alu_y < hi);

    // Divide: restoring shift-subtract. hi[31] set means the shifted partial
    // remainder is really 33 bits wide and always exceeds the divisor.
    assign sh     = {hi[XLEN-2:0], lo[XLEN-1]};
    assign ge     = hi[XLEN-1] | (sh >= mreg);

`ifdef MULDIV_SIGNED_EN
    logic              sgn_r;
    logic              op_div_r;
    logic              neg_q_r;     // quotient / product must be negated
    logic              neg_r_r;     // remainder must be negated (dividend negative)
    logic [2*XLEN-1:0] prod_neg;

    assign in_a       = (is_signed && opa[XLEN-1]) ? -opa : opa;
    assign in_b       = (is_signed && opb[XLEN-1]) ? -opb : opb;
    assign exit_state = sgn_r ? S_FIX : S_DONE;
    assign prod_neg   = -{hi, lo};
`else
    logic unused_signed;

    assign unused_signed = is_signed;
    assign in_a          = opa;
    assign in_b          = opb;
    assign exit_state    = S_DONE;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            count    <= '0;
            hi       <= '0;
            lo       <= '0;
            mreg     <= '0;
`ifdef MULDIV_SIGNED_EN
            sgn_r    <= 1'b0;
            op_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
`endif
        end else if (accept) begin
            count    <= '0;
            hi       <= '0;
            lo       <= is_div ? in_a : in_b;
            mreg     <= is_div ? in_b : in_a;
            state    <= is_div ? S_DIV : S_MUL;
`ifdef MULDIV_SIGNED_EN
            sgn_r    <= is_signed;
            op_div_r <= is_div;
            neg_q_r  <= is_signed & (opa[XLEN-1] ^ opb[XLEN-1]);
            neg_r_r  <= is_signed & opa[XLEN-1];
`endif
        end else begin
            case (state)
                S_MUL: begin
                    hi    <= {carry, alu_y[XLEN-1:1]};
                    lo    <= {alu_y[0], lo[XLEN-1:1]};
                    count <= count + 1'b1;
                    if (last) state <= exit_state;
                end
                S_DIV: begin
                    hi    <= ge ? alu_y : sh;
                    lo    <= {lo[XLEN-2:0], ge};
                    count <= count + 1'b1;
                    if (last) state <= exit_state;
                end
`ifdef MULDIV_SIGNED_EN
                S_FIX: begin
                    if (op_div_r) begin
                        if (neg_q_r) lo <= -lo;
                        if (neg_r_r) hi <= -hi;
                    end else if (neg_q_r) begin
                        {hi, lo} <= prod_neg;
                    end
                    state <= S_DONE;
                end
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        alu_grant = 1'b0;
        alu_op    = OP_ZERO;
        alu_a     = '0;
        alu_b     = '0;
        case (state)
            S_MUL: begin
                alu_grant = 1'b1;
                alu_op    = OP_ADD;
                alu_a     = hi;
                alu_b     = lo[0] ? mreg : '0;
            end
            S_DIV: begin
                alu_grant = 1'b1;
                alu_op    = OP_SUB;
                alu_a     = sh;
                alu_b     = mreg;
            end
            default: ;
        endcase
    end

`ifdef MULDIV_SIGNED_EN
    assign busy  = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
`else
    assign busy  = (state == S_MUL) || (state == S_DIV);
`endif
    assign done  = (state == S_DONE);
    assign stall = busy | accept;

endmodule

// File: tb/tb_muldiv_alu_seq.sv
// tb/tb_muldiv_alu_seq.sv - self-checking scoreboard bench for muldiv_alu_seq
module tb_muldiv_alu_seq;

`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_div = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic [31:0] alu_y;
    logic        alu_grant;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] sb_q[$];

    muldiv_alu_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_div(is_div), .is_signed(is_signed),
        .opa(opa), .opb(opb), .alu_y(alu_y), .alu_grant(alu_grant), .alu_op(alu_op),
        .alu_a(alu_a), .alu_b(alu_b), .stall(stall), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Shared EX-stage ALU seen by the block
    always_comb begin
        case (alu_op)
            4'b0010: alu_y = alu_a + alu_b;
            4'b0110: alu_y = alu_a - alu_b;
            default: alu_y = 32'h0;
        endcase
    end

    // Reference result {hi, lo}
    function automatic logic [63:0] model(input bit d, input bit s, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] r;
        bit          sg;
        sg = s && SIGNED_BUILD;
        if (!d) begin
            if (sg) r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            else    r = {32'b0, a} * {32'b0, b};
        end else if (b == 32'h0) begin
            r = {a, (sg && a[31]) ? 32'h1 : 32'hFFFF_FFFF};
        end else if (sg) begin
            r = {$signed(a) % $signed(b), $signed(a) / $signed(b)};
        end else begin
            r = {a % b, a / b};
        end
        return r;
    endfunction

    task automatic issue(input bit d, input logic [31:0] a, input logic [31:0] b, input bit s,
                         output logic st);
        @(negedge clk);
        start = 1'b1; is_div = d; opa = a; opb = b; is_signed = s;
        sb_q.push_back(model(d, s, a, b));
        #1 st = stall;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done; optionally pokes start at one cycle
    task automatic wait_done(input int poke_at, output int cyc, output int grants,
                             output int nostall, output logic [31:0] h, output logic [31:0] l,
                             output bit ok);
        cyc = 0; grants = 0; nostall = 0; h = '0; l = '0; ok = 1'b0;
        while (cyc < 100) begin
            if (done) begin
                ok = 1'b1; h = hi; l = lo;
                break;
            end
            if (alu_grant) grants++;
            if (!stall) nostall++;
            if (cyc == poke_at) begin
                start = 1'b1; is_div = ~is_div; opa = 32'h0000_1234; opb = 32'h0000_0055;
            end
            @(posedge clk);
            #1 start = 1'b0;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, alu_grant, stall, alu_op} !== 8'b0000_1000) begin
            n_bad++;
            $display("FAIL reset_status: got %b want 00001000", {busy, done, alu_grant, stall, alu_op});
        end
        n_cmp++;
        if ({hi, lo, alu_a, alu_b} !== 128'h0) begin
            n_bad++;
            $display("FAIL reset_regs: got hi=%h lo=%h a=%h b=%h want all 0", hi, lo, alu_a, alu_b);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_mul_small();
        logic st; int cyc, gr, ns; logic [31:0] h, l; bit ok; logic [63:0] exp;
        issue(1'b0, 32'd7, 32'd6, 1'b0, st);
        wait_done(-1, cyc, gr, ns, h, l, ok);
        exp = sb_q.pop_front();
        n_cmp++;
        if (!ok || {h, l} !== exp) begin
            n_bad++;
            $display("FAIL mul_small: got ok=%0d %h want %h", ok, {h, l}, exp);
        end
        n_cmp++;
        if (cyc + 1 != 33) begin
            n_bad++;
            $display("FAIL mul_small_latency: got %0d want 33", cyc + 1);
        end
        n_cmp++;
        if (gr != 32) begin
            n_bad++;
            $display("FAIL mul_small_grant: got %0d cycles want 32", gr);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({done, busy, hi, lo} !== {2'b00, exp}) begin
            n_bad++;
            $display("FAIL done_one_cycle: got done=%b busy=%b %h want 0 0 %h", done, busy, {hi, lo}, exp);
        end
    endtask

    task automatic test_mul_carry();
        logic st; int cyc, gr, ns; logic [31:0] h, l; bit ok; logic [63:0] exp;
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, st);
        wait_done(-1, cyc, gr, ns, h, l, ok);
        exp = sb_q.pop_front();
        n_cmp++;
        if (!ok || {h, l} !== exp || {h, l} !== 64'hFFFF_FFFE_0000_0001) begin
            n_bad++;
            $display("FAIL mul_carry: got %h want FFFFFFFE00000001", {h, l});
        end
    endtask

    task automatic test_div();
        logic st; int cyc, gr, ns; logic [31:0] h, l; bit ok; logic [63:0] exp;
        logic [31:0] dv[2] = '{32'd100, 32'd5};
        logic [31:0] ds[2] = '{32'd7, 32'd0};
        for (int i = 0; i < 2; i++) begin
            issue(1'b1, dv[i], ds[i], 1'b0, st);
            wait_done(-1, cyc, gr, ns, h, l, ok);
            exp = sb_q.pop_front();
            n_cmp++;
            if (!ok || {h, l} !== exp) begin
                n_bad++;
                $display("FAIL div_%0d: got hi=%h lo=%h want %h", i, h, l, exp);
            end
            n_cmp++;
            if (st !== 1'b1 || ns != 0) begin
                n_bad++;
                $display("FAIL div_stall_%0d: got start_stall=%b low_cycles=%0d want 1 0", i, st, ns);
            end
            n_cmp++;
            if (cyc + 1 != 33) begin
                n_bad++;
                $display("FAIL div_latency_%0d: got %0d want 33", i, cyc + 1);
            end
        end
    endtask

    task automatic test_ignored_start();
        logic st; int cyc, gr, ns; logic [31:0] h, l; bit ok; logic [63:0] exp;
        issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, st);
        wait_done(10, cyc, gr, ns, h, l, ok);
        exp = sb_q.pop_front();
        n_cmp++;
        if (!ok || {h, l} !== exp || cyc + 1 != 33) begin
            n_bad++;
            $display("FAIL ignored_start: got %h lat=%0d want %h lat=33", {h, l}, cyc + 1, exp);
        end
    endtask

    task automatic test_reset_abort();
        logic st; int cyc, gr, ns; logic [31:0] h, l; bit ok; logic [63:0] exp; int dones;
        issue(1'b0, 32'hDEAD_BEEF, 32'h0000_0003, 1'b0, st);
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        void'(sb_q.pop_back());
        n_cmp++;
        if ({busy, done, alu_grant, stall, alu_op, hi, lo, alu_a, alu_b} !== {8'b0000_1000, 128'h0}) begin
            n_bad++;
            $display("FAIL abort_outputs: got st=%b op=%b hi=%h lo=%h a=%h b=%h want reset values",
                     {busy, done, alu_grant, stall}, alu_op, hi, lo, alu_a, alu_b);
        end
        @(negedge clk) rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            n_bad++;
            $display("FAIL abort_no_done: got %0d done pulses want 0", dones);
        end
        issue(1'b1, 32'd1000, 32'd3, 1'b0, st);
        wait_done(-1, cyc, gr, ns, h, l, ok);
        exp = sb_q.pop_front();
        n_cmp++;
        if (!ok || {h, l} !== exp) begin
            n_bad++;
            $display("FAIL abort_restart: got %h want %h", {h, l}, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic st; int cyc, gr, ns; logic [31:0] h, l; bit ok; logic [63:0] exp;
        issue(1'b1, 32'd100, 32'd7, 1'b0, st);
        wait_done(-1, cyc, gr, ns, h, l, ok);
        exp = sb_q.pop_front();
        n_cmp++;
        if (!ok || {h, l} !== exp) begin
            n_bad++;
            $display("FAIL b2b_first: got %h want %h", {h, l}, exp);
        end
        start = 1'b1; is_div = 1'b0; opa = 32'h0001_0001; opb = 32'h0000_FFFF; is_signed = 1'b0;
        sb_q.push_back(model(1'b0, 1'b0, opa, opb));
        #1;
        n_cmp++;
        if (stall !== 1'b1 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_accept_stall: got stall=%b done=%b want 1 1", stall, done);
        end
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(-1, cyc, gr, ns, h, l, ok);
        exp = sb_q.pop_front();
        n_cmp++;
        if (!ok || {h, l} !== exp || cyc + 1 != 33) begin
            n_bad++;
            $display("FAIL b2b_second: got %h gap=%0d want %h gap=33", {h, l}, cyc + 1, exp);
        end
    endtask

    task automatic test_random();
        logic st; int cyc, gr, ns; logic [31:0] h, l, a, b; bit ok, d; logic [63:0] exp;
        for (int i = 0; i < 8; i++) begin
            d = i[0];
            a = $urandom;
            b = (d && i[1]) ? 32'($urandom_range(1, 65535)) : $urandom;
            issue(d, a, b, 1'b0, st);
            wait_done(-1, cyc, gr, ns, h, l, ok);
            exp = sb_q.pop_front();
            n_cmp++;
            if (!ok || {h, l} !== exp) begin
                n_bad++;
                $display("FAIL random_%0d: div=%0d a=%h b=%h got %h want %h", i, d, a, b, {h, l}, exp);
            end
        end
    endtask

    task automatic test_signed();
        logic st; int cyc, gr, ns; logic [31:0] h, l; bit ok; logic [63:0] exp;
        bit          dl[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] al[4] = '{-32'sd3, -32'sd7, 32'd7, -32'sd4};
        logic [31:0] bl[4] = '{32'd5, 32'd2, -32'sd2, -32'sd6};
        for (int i = 0; i < 4; i++) begin
            issue(dl[i], al[i], bl[i], 1'b1, st);
            wait_done(-1, cyc, gr, ns, h, l, ok);
            exp = sb_q.pop_front();
            n_cmp++;
            if (!ok || {h, l} !== exp) begin
                n_bad++;
                $display("FAIL signed_%0d: got %h want %h", i, {h, l}, exp);
            end
            n_cmp++;
            if (cyc + 1 != (SIGNED_BUILD ? 34 : 33)) begin
                n_bad++;
                $display("FAIL signed_latency_%0d: got %0d want %0d", i, cyc + 1, SIGNED_BUILD ? 34 : 33);
            end
        end
        is_signed = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mul_small();
        test_mul_carry();
        test_div();
        test_ignored_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        test_signed();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_alu_seq.md
Name: muldiv_alu_seq

Overview:
- Multi-cycle HI/LO unit for the pipelined MIPS core. It executes MULTU/DIVU by borrowing the shared 32-bit EX-stage ALU for 32 iterations.
- It owns the ALU-input mux select, drives the ALU op and operands while it holds the ALU, and stalls the pipeline until the result is ready.
- HI/LO outputs feed MFHI/MFLO.

Parameters:
- XLEN, 32, operand width. Fixed at 32 for this core; other values are unsupported.
- CNT_W, 5, iteration counter width; XLEN = 2^CNT_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request from EX: start an operation with the operands below
- is_div  in  1  1 = divide, 0 = multiply; sampled at start
- is_signed  in  1  signed-operation request; used only when MULDIV_SIGNED_EN is defined
- opa  in  32  rs value: multiplicand or dividend
- opb  in  32  rt value: multiplier or divisor
- alu_y  in  32  shared ALU result
- alu_grant  out  1  1 = ALU inputs are taken from this block
- alu_op  out  4  ALU op code: 4'b0010 add, 4'b0110 sub, 4'b1000 zero
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- stall  out  1  freeze IF/ID/EX
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when hi/lo become valid
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, count=0.
  - hi, lo, divisor/multiplicand register = 0.
  - busy=0, done=0, alu_grant=0, alu_op=4'b1000, alu_a=0, alu_b=0.
  - Reset during an operation aborts it; no done pulse is produced.
- States: IDLE, MUL, DIV, FIX (FIX exists only with the macro), DONE.
- Start acceptance:
  - start is accepted only in IDLE or DONE; it is ignored in all other states.
  - On accept:
    - MUL: lo<=opb, hi<=0, mcand<=opa.
    - DIV: lo<=opa, hi<=0, dsor<=opb.
  - count<=0, then the FSM moves to MUL or DIV.
- MUL iteration (one per cycle):
  - Drive alu_a=hi, alu_b=lo[0]?mcand:0, alu_op=0010.
  - carry=(alu_y<hi), unsigned compare done locally.
  - hi<={carry,alu_y[31:1]}; lo<={alu_y[0],lo[31:1]}.
- DIV iteration (one per cycle):
  - sh={hi[30:0],lo[31]}; drive alu_a=sh, alu_b=dsor, alu_op=0110.
  - ge=hi[31] | (sh>=dsor), unsigned.
  - hi<=ge?alu_y:sh; lo<={lo[30:0],ge}.
- Iteration exit:
  - count increments every iteration.
  - After the iteration with count==31, go to DONE (or to FIX when signed).
- Results:
  - MUL: {hi,lo} = 64-bit product.
  - DIV: lo = quotient, hi = remainder.
- Divide by zero falls out of the algorithm: lo=32'hFFFFFFFF, hi=dividend. No trap, no extra cycles.
- DONE lasts one cycle:
  - done=1, busy=0.
  - hi/lo are held until the next accepted start.
  - A start in DONE is accepted as a new start.
- ALU ownership:
  - alu_grant=1 exactly in MUL/DIV.
  - Outside MUL/DIV: alu_op=1000, alu_a=alu_b=0.
  - All ALU-facing outputs are combinational from state and registers.
- Status:
  - busy=1 in MUL/DIV/FIX.
  - stall = busy | (start & accepted).
- Latency, unsigned: start accepted at edge N, done=1 during cycle N+33 (32 iterations + DONE).
- alu_y is used in the same cycle it is driven; it must be a purely combinational return path.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined:
  - When start & is_signed, the operands are replaced locally by their absolute values, and their signs are stored.
  - After the last iteration the FSM enters FIX for one cycle:
    - MUL: negate the 64-bit {hi,lo} if the signs differ.
    - DIV: negate lo if the signs differ; negate hi if the dividend is negative.
  - Signed latency is 34 cycles. is_signed=0 behaves exactly as the unsigned path.
- Undefined:
  - is_signed is ignored, the FIX state is absent, all operations are unsigned, latency is 33.

Test Plan:
- Reset, then MULTU opa=32'h0000_0007 opb=32'h0000_0006 -> done at cycle 33; hi=0, lo=42; alu_grant=1 for exactly 32 cycles.
- MULTU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001 (exercises the carry path).
- DIVU 100/7 -> lo=14, hi=2; DIVU 5/0 -> lo=32'hFFFF_FFFF, hi=5; stall high throughout both.
- Start pulsed again at iteration 10 of a MULTU -> ignored; the original result is unchanged. rst_n dropped at iteration 20 -> all outputs at reset values immediately, no done; a new start is accepted afterwards.
- Back-to-back: start asserted during DONE of a DIVU -> new MULTU accepted; done pulses 33 cycles apart; hi/lo of the first operation are visible during DONE.
- With MULDIV_SIGNED_EN:
  - MULT -3 x 5 -> {hi,lo}=64'hFFFF_FFFF_FFFF_FFF1.
  - DIV -7/2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF; done at cycle 34.
